decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter N, default 64, data and register width; SHALL be at least 32.
REQ-002 Parameter AW, default 5, register address width; the register count SHALL be 2**AW, and register 2**AW-1 is XZR.
REQ-003 Parameter CW, default 8, width of the opaque control bundle carried to execute.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 instr_D  input  32  instruction in decode.
REQ-008 valid_D  input  1  instr_D holds a real instruction.
REQ-009 reg2loc_D  input  1  0 selects ra2=instr_D[20:16]; 1 selects ra2=instr_D[4:0].
REQ-010 memRead_D  input  1  instruction is a load.
REQ-011 ctrl_D  input  CW  control bundle for execute.
REQ-012 regWrite_W  input  1  writeback enable.
REQ-013 wa3_W  input  AW  writeback address.
REQ-014 writeData3_W  input  N  writeback data.
REQ-015 flush_E  input  1  branch taken; discard the instruction entering execute.
REQ-016 stall_D  output  1  load-use hazard; upstream holds PC and IF/ID.
REQ-017 readData1_E, readData2_E  output  N  registered operands.
REQ-018 signImm_E  output  N  registered extended immediate.
REQ-019 ra1_E, ra2_E, wa3_E  output  AW  registered source and destination addresses.
REQ-020 ctrl_E  output  CW; memRead_E  output  1; valid_E  output  1  registered control.

Function
REQ-021 Address decode: ra1=instr_D[9:5]; ra2 is selected as in REQ-009; wa=instr_D[4:0].
REQ-022 Register file writes on the rising clk edge when regWrite_W=1 and wa3_W is not XZR; writes to XZR are ignored.
REQ-023 Reading XZR SHALL return 0 regardless of any write.
REQ-024 Write-through bypass: when regWrite_W=1, wa3_W equals the read address, and the address is not XZR, the read port SHALL return writeData3_W in the same cycle.
REQ-025 Sign extension by instr_D[31:21]:
- 11111000010 (LDUR) or 11111000000 (STUR): sext(instr_D[20:12]).
- 10110100xxx (CBZ): sext(instr_D[23:5]).
- 000101xxxxx (B): sext(instr_D[25:0]).
- All other opcodes: 0. All results are extended to N bits.
REQ-026 Hazard condition: valid_E & memRead_E & (wa3_E != XZR) & valid_D & (wa3_E==ra1 | wa3_E==ra2).
REQ-027 stall_D = hazard & ~flush_E; it is combinational in the same cycle.
REQ-028 ID/EX register updates on every rising edge, one-cycle latency; there is no hold mode.
REQ-029 Update priority: flush_E, then hazard, then normal.
REQ-030 Flush or hazard: ID/EX loads a bubble with all output fields 0.
REQ-031 Normal update: ID/EX loads the decode values; valid_E=valid_D.
REQ-032 When valid_D=0, the load proceeds with valid_E=0; ctrl_E and memRead_E SHALL be forced to 0.
REQ-033 Simultaneous writeback to a register and a hazard-free read of it: the bypassed value is latched, per REQ-024.

Reset
REQ-034 While reset=0, all registers and all ID/EX fields SHALL be 0 asynchronously, and stall_D=0.
REQ-035 The first rising edge after reset deasserts performs a normal update.
REQ-036 Reset mid-stall: the bubble and the pending load SHALL be discarded, and no register write occurs while reset=0.

Verification
REQ-037 Reset, then read X1 and X2 -> readData1_E=0 and readData2_E=0 one cycle later; all outputs are 0 during reset.
REQ-038 Write X3=64'h1234 with ADD X5,X3,X3 in decode the same cycle -> next cycle readData1_E=readData2_E=64'h1234 (bypass).
REQ-039 Write XZR=64'hFFFF, then read X31 -> 0.
REQ-040 LDUR X2,[X1,#-8], then ADD X4,X2,X3 in decode -> stall_D=1 for one cycle, next valid_E=0 with ctrl_E=0; signImm_E for the LDUR = -8 (64'hFFFF_FFFF_FFFF_FFF8).
REQ-041 Same hazard with flush_E=1 -> stall_D=0, and the next ID/EX holds all fields 0.
REQ-042 CBZ with imm19=19'h7FFFF, then B with imm26=1 -> signImm_E=-1, then signImm_E=1, on consecutive cycles.

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Decode stage of a five-stage ARMv8-subset pipeline. It contains the register
//   file (with write-through bypass and a hard-wired zero register), the
//   immediate sign-extender, the load-use hazard detector and the ID/EX
//   pipeline register.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   instr_D, valid_D        instruction in decode and its valid flag
//   reg2loc_D               second read address: 0 -> instr[20:16], 1 -> instr[4:0]
//   memRead_D, ctrl_D       control for execute (load flag, opaque bundle)
//   regWrite_W, wa3_W,
//   writeData3_W            writeback port
//   flush_E                 branch taken: squash the instruction entering execute
//   stall_D                 load-use hazard, upstream holds PC and IF/ID
//   *_E                     registered ID/EX outputs
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int N  = 64,
  parameter int AW = 5,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_D,
  input  logic          valid_D,
  input  logic          reg2loc_D,
  input  logic          memRead_D,
  input  logic [CW-1:0] ctrl_D,
  input  logic          regWrite_W,
  input  logic [AW-1:0] wa3_W,
  input  logic [N-1:0]  writeData3_W,
  input  logic          flush_E,
  output logic          stall_D,
  output logic [N-1:0]  readData1_E,
  output logic [N-1:0]  readData2_E,
  output logic [N-1:0]  signImm_E,
  output logic [AW-1:0] ra1_E,
  output logic [AW-1:0] ra2_E,
  output logic [AW-1:0] wa3_E,
  output logic [CW-1:0] ctrl_E,
  output logic          memRead_E,
  output logic          valid_E
);

  localparam int            NREG = 1 << AW;
  localparam logic [AW-1:0] XZR  = '1;

  if (N < 32) begin : g_width_check
    $error("decode_stage: N must be at least 32");
  end

  typedef struct packed {
    logic          valid;
    logic          mem_read;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa3;
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic [N-1:0]  imm;
  } id_ex_t;

  logic [N-1:0]  rf_q [NREG];
  logic [AW-1:0] ra1, ra2, wa;
  logic [N-1:0]  rd1, rd2, imm;
  logic          hazard;
  id_ex_t        id_ex_d, id_ex_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign ra1 = instr_D[9:5];
  assign ra2 = reg2loc_D ? instr_D[4:0] : instr_D[20:16];
  assign wa  = instr_D[4:0];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  // NOTE: this memory is cleared by the asynchronous reset because every
  // architectural register must read as zero while and after reset is low;
  // that forces a flop-based array rather than an SRAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (regWrite_W && (wa3_W != XZR)) begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
      rf_q[wa3_W] <= writeData3_W;
    end
  end

  // Read ports: XZR reads zero; a same-cycle writeback to the read address is
  // forwarded so the value latched into ID/EX is the one being written.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch forms.
    rd1 = rf_q[ra1];
    rd2 = rf_q[ra2];
    if (regWrite_W && (wa3_W == ra1)) rd1 = writeData3_W;
    if (regWrite_W && (wa3_W == ra2)) rd2 = writeData3_W;
    if (ra1 == XZR) rd1 = '0;
    if (ra2 == XZR) rd2 = '0;
  end

  // ---------------------------------------------------------------------------
  // Immediate extension, selected by the 11-bit opcode field
  // ---------------------------------------------------------------------------
  always_comb begin
    imm = '0;
    if ((instr_D[31:21] == 11'b11111000010) || (instr_D[31:21] == 11'b11111000000)) begin
      imm = {{(N-9){instr_D[20]}}, instr_D[20:12]};           // LDUR / STUR
    end else if (instr_D[31:24] == 8'b10110100) begin
      imm = {{(N-19){instr_D[23]}}, instr_D[23:5]};           // CBZ
    end else if (instr_D[31:26] == 6'b000101) begin
      imm = {{(N-26){instr_D[25]}}, instr_D[25:0]};           // B
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: the load in execute writes a register decode is reading.
  // A taken branch squashes the dependent instruction, so no stall is needed.
  // ---------------------------------------------------------------------------
  assign hazard  = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.wa3 != XZR) &&
                   valid_D && ((id_ex_q.wa3 == ra1) || (id_ex_q.wa3 == ra2));
  assign stall_D = hazard && !flush_E;

  // ---------------------------------------------------------------------------
  // ID/EX register: flush and hazard both insert an all-zero bubble
  // ---------------------------------------------------------------------------
  always_comb begin
    id_ex_d = '0;
    if (!flush_E && !hazard) begin
      id_ex_d.valid    = valid_D;
      id_ex_d.mem_read = valid_D && memRead_D;
      id_ex_d.ctrl     = valid_D ? ctrl_D : '0;
      id_ex_d.ra1      = ra1;
      id_ex_d.ra2      = ra2;
      id_ex_d.wa3      = wa;
      id_ex_d.rd1      = rd1;
      id_ex_d.rd2      = rd2;
      id_ex_d.imm      = imm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) id_ex_q <= '0;
    else        id_ex_q <= id_ex_d;
  end

  assign valid_E     = id_ex_q.valid;
  assign memRead_E   = id_ex_q.mem_read;
  assign ctrl_E      = id_ex_q.ctrl;
  assign ra1_E       = id_ex_q.ra1;
  assign ra2_E       = id_ex_q.ra2;
  assign wa3_E       = id_ex_q.wa3;
  assign readData1_E = id_ex_q.rd1;
  assign readData2_E = id_ex_q.rd2;
  assign signImm_E   = id_ex_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage (N=64, AW=5, CW=8). A behavioural model
//   (register array plus the expected ID/EX contents) is compared against the
//   DUT on every falling edge; literal checks at key points pin the model.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D;
  logic        valid_D, reg2loc_D, memRead_D;
  logic [7:0]  ctrl_D;
  logic        regWrite_W;
  logic [4:0]  wa3_W;
  logic [63:0] writeData3_W;
  logic        flush_E;
  logic        stall_D;
  logic [63:0] readData1_E, readData2_E, signImm_E;
  logic [4:0]  ra1_E, ra2_E, wa3_E;
  logic [7:0]  ctrl_E;
  logic        memRead_E, valid_E;

  int total = 0;
  int bad   = 0;

  decode_stage #(.N(64), .AW(5), .CW(8)) dut (
    .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D),
    .reg2loc_D(reg2loc_D), .memRead_D(memRead_D), .ctrl_D(ctrl_D),
    .regWrite_W(regWrite_W), .wa3_W(wa3_W), .writeData3_W(writeData3_W),
    .flush_E(flush_E), .stall_D(stall_D), .readData1_E(readData1_E),
    .readData2_E(readData2_E), .signImm_E(signImm_E), .ra1_E(ra1_E),
    .ra2_E(ra2_E), .wa3_E(wa3_E), .ctrl_E(ctrl_E), .memRead_E(memRead_E),
    .valid_E(valid_E)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instruction builders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] f_add(input int rd, input int rn, input int rm);
    return {11'b10001011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] f_ldur(input int rt, input int rn, input int off);
    return {11'b11111000010, 9'(off), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] f_stur(input int rt, input int rn, input int off);
    return {11'b11111000000, 9'(off), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] f_cbz(input logic [18:0] off, input int rt);
    return {8'b10110100, off, 5'(rt)};
  endfunction
  function automatic logic [31:0] f_b(input logic [25:0] off);
    return {6'b000101, off};
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        valid, mem_read;
    logic [7:0]  ctrl;
    logic [4:0]  ra1, ra2, wa3;
    logic [63:0] rd1, rd2, imm;
  } exp_t;

  exp_t        m_e;
  logic [63:0] m_regs [32];

  function automatic logic [63:0] m_imm(input logic [31:0] ins);
    longint v = 0;
    if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) v = longint'($signed(ins[20:12]));
    else if (ins[31:24] == 8'hB4)                        v = longint'($signed(ins[23:5]));
    else if (ins[31:26] == 6'h05)                        v = longint'($signed(ins[25:0]));
    return 64'(v);
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (regWrite_W && wa3_W == a) return writeData3_W;
    return m_regs[a];
  endfunction

  function automatic logic [4:0] m_ra2();
    return reg2loc_D ? instr_D[4:0] : instr_D[20:16];
  endfunction

  function automatic logic m_hazard();
    return m_e.valid && m_e.mem_read && m_e.wa3 != 5'd31 && valid_D &&
           (m_e.wa3 == instr_D[9:5] || m_e.wa3 == m_ra2());
  endfunction

  always @(posedge clk or negedge reset) begin
    exp_t nxt;
    if (!reset) begin
      m_e = '0;
      foreach (m_regs[i]) m_regs[i] = 64'd0;
    end else begin
      nxt = '0;
      if (!flush_E && !m_hazard()) begin
        nxt.valid    = valid_D;
        nxt.mem_read = valid_D & memRead_D;
        nxt.ctrl     = valid_D ? ctrl_D : 8'd0;
        nxt.ra1      = instr_D[9:5];
        nxt.ra2      = m_ra2();
        nxt.wa3      = instr_D[4:0];
        nxt.rd1      = m_read(instr_D[9:5]);
        nxt.rd2      = m_read(m_ra2());
        nxt.imm      = m_imm(instr_D);
      end
      if (regWrite_W && wa3_W != 5'd31) m_regs[wa3_W] = writeData3_W;
      m_e = nxt;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("cyc_stall",   stall_D,     reset ? 64'(m_hazard() && !flush_E) : 64'd0);
    check("cyc_valid",   valid_E,     m_e.valid);
    check("cyc_memRead", memRead_E,   m_e.mem_read);
    check("cyc_ctrl",    ctrl_E,      m_e.ctrl);
    check("cyc_ra1",     ra1_E,       m_e.ra1);
    check("cyc_ra2",     ra2_E,       m_e.ra2);
    check("cyc_wa3",     wa3_E,       m_e.wa3);
    check("cyc_rd1",     readData1_E, m_e.rd1);
    check("cyc_rd2",     readData2_E, m_e.rd2);
    check("cyc_imm",     signImm_E,   m_e.imm);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [31:0] ins, input logic v, input logic r2l,
                       input logic mr, input logic [7:0] c);
    instr_D = ins; valid_D = v; reg2loc_D = r2l; memRead_D = mr; ctrl_D = c;
  endtask

  task automatic wb(input logic we, input int a, input logic [63:0] d);
    regWrite_W = we; wa3_W = 5'(a); writeData3_W = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush_E = 1'b0;
    drive(f_add(4, 1, 2), 1'b1, 1'b0, 1'b0, 8'h11);
    wb(1'b1, 1, 64'hAAAA);             // must be ignored while in reset
    tick();
    check("rst_rd1",   readData1_E, 64'd0);
    check("rst_valid", valid_E,     64'd0);
    check("rst_stall", stall_D,     64'd0);
    tick();
    wb(1'b0, 0, 64'd0);
    reset = 1'b1;

    // Read X1, X2 after reset
    tick();
    check("post_rst_rd1", readData1_E, 64'd0);
    check("post_rst_rd2", readData2_E, 64'd0);
    check("post_rst_ctrl", ctrl_E, 64'h11);

    // Write X3 with ADD X5,X3,X3 in decode: bypass
    drive(f_add(5, 3, 3), 1'b1, 1'b0, 1'b0, 8'h22);
    wb(1'b1, 3, 64'h1234);
    tick();
    check("byp_rd1", readData1_E, 64'h1234);
    check("byp_rd2", readData2_E, 64'h1234);
    check("byp_wa3", wa3_E, 64'd5);

    // Write XZR, read X31
    drive(f_add(6, 31, 31), 1'b1, 1'b0, 1'b0, 8'h22);
    wb(1'b1, 31, 64'hFFFF);
    tick();
    check("xzr_byp_rd1", readData1_E, 64'd0);
    wb(1'b0, 0, 64'd0);
    drive(f_add(6, 31, 3), 1'b1, 1'b0, 1'b0, 8'h22);
    tick();
    check("xzr_rd1",    readData1_E, 64'd0);
    check("stored_rd2", readData2_E, 64'h1234);

    // LDUR X2,[X1,#-8] with X1 written in the same cycle
    drive(f_ldur(2, 1, -8), 1'b1, 1'b0, 1'b1, 8'h80);
    wb(1'b1, 1, 64'd100);
    tick();
    wb(1'b0, 0, 64'd0);
    check("ldur_imm",  signImm_E, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_mr",   memRead_E, 64'd1);
    check("ldur_rd1",  readData1_E, 64'd100);

    // ADD X4,X2,X3 -> load-use stall for one cycle
    drive(f_add(4, 2, 3), 1'b1, 1'b0, 1'b0, 8'h11);
    #1 check("hz_stall", stall_D, 64'd1);
    tick();
    check("hz_bubble_valid", valid_E, 64'd0);
    check("hz_bubble_ctrl",  ctrl_E,  64'd0);
    check("hz_stall_clear",  stall_D, 64'd0);
    tick();
    check("hz_retry_valid", valid_E, 64'd1);
    check("hz_retry_rd2",   readData2_E, 64'h1234);

    // Same hazard with a taken branch flushing
    drive(f_ldur(2, 1, -8), 1'b1, 1'b0, 1'b1, 8'h80);
    tick();
    drive(f_add(4, 2, 3), 1'b1, 1'b0, 1'b0, 8'h11);
    flush_E = 1'b1;
    #1 check("fl_stall", stall_D, 64'd0);
    tick();
    flush_E = 1'b0;
    check("fl_valid", valid_E, 64'd0);
    check("fl_ra1",   ra1_E,   64'd0);
    check("fl_rd2",   readData2_E, 64'd0);

    // CBZ imm19 = all ones, then B imm26 = 1, then STUR #5
    drive(f_cbz(19'h7FFFF, 0), 1'b1, 1'b1, 1'b0, 8'h44);
    tick();
    check("cbz_imm", signImm_E, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(f_b(26'd1), 1'b1, 1'b0, 1'b0, 8'h08);
    tick();
    check("b_imm", signImm_E, 64'd1);
    drive(f_stur(2, 1, 5), 1'b1, 1'b1, 1'b0, 8'h40);
    tick();
    check("stur_imm", signImm_E, 64'd5);
    check("stur_ra2", ra2_E, 64'd2);

    // Invalid decode slot: control forced to zero, no hazard afterwards
    drive(f_ldur(2, 1, 3), 1'b0, 1'b0, 1'b1, 8'hFF);
    tick();
    check("inv_mr",   memRead_E, 64'd0);
    check("inv_ctrl", ctrl_E,    64'd0);
    check("inv_wa3",  wa3_E,     64'd2);
    drive(f_add(4, 2, 3), 1'b1, 1'b0, 1'b0, 8'h11);
    #1 check("inv_no_stall", stall_D, 64'd0);
    tick();
    check("inv_next_valid", valid_E, 64'd1);

    // Reset in the middle of a stall, with a writeback pending
    drive(f_ldur(2, 1, -8), 1'b1, 1'b0, 1'b1, 8'h80);
    tick();
    drive(f_add(4, 2, 3), 1'b1, 1'b0, 1'b0, 8'h11);
    #1 check("mid_stall", stall_D, 64'd1);
    #1 reset = 1'b0;
    wb(1'b1, 7, 64'hDEAD);
    #1 check("mid_rst_stall", stall_D,   64'd0);
    check("mid_rst_mr",    memRead_E, 64'd0);
    check("mid_rst_imm",   signImm_E, 64'd0);
    tick();
    wb(1'b0, 0, 64'd0);
    reset = 1'b1;
    drive(f_add(9, 7, 3), 1'b1, 1'b0, 1'b0, 8'h11);
    tick();
    check("after_rst_x7", readData1_E, 64'd0);
    check("after_rst_x3", readData2_E, 64'd0);
    check("after_rst_valid", valid_E, 64'd1);

    drive(32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
